// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared types and constants for the decrypted-message checker
// and the key-search controller that consumes its verdict.
//   chk_state_t      : checker FSM state encoding
//   CHAR_*           : printable-plaintext character bounds
//   DEFAULT_MSG_LEN  : message length in bytes checked by default
package decrypt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_ADDR,
        WAIT,
        CHECK,
        DONE
    } chk_state_t;

    localparam logic [7:0]  CHAR_SPACE      = 8'h20;
    localparam logic [7:0]  CHAR_LO_A       = 8'h61;
    localparam logic [7:0]  CHAR_LO_Z       = 8'h7A;
    localparam int unsigned DEFAULT_MSG_LEN = 32;

endpackage

// File: rtl/char_is_legal.sv
// char_is_legal: combinational test for printable plaintext.
// A byte is legal when it is a lowercase letter 'a'..'z' or a space.
// Ports:
//   char_i  [7:0] : byte under test
//   legal_o       : 1 when char_i is legal
module char_is_legal
    import decrypt_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       legal_o
);

    always_comb begin
        legal_o = ((char_i >= CHAR_LO_A) && (char_i <= CHAR_LO_Z)) || (char_i == CHAR_SPACE);
    end

endmodule

// File: rtl/message_checker_fsm.sv
// message_checker_fsm: reads the decrypted-message RAM back byte by byte and
// reports whether every byte is printable plaintext. Aborts on the first
// illegal byte and reports its address and value.
// Ports:
//   clock       : sole clock, rising edge
//   reset_n     : asynchronous active-low reset
//   start       : request a check, only honoured in IDLE
//   q           : RAM read data
//   address     : registered RAM read address
//   busy        : high in every state except IDLE
//   finish      : one-cycle pulse once the verdict is final
//   valid       : 1 = all bytes legal; held until the next accepted start
//   fail_index  : address of the first illegal byte (0 when valid)
//   bad_char    : value of the first illegal byte (0 when valid)
module message_checker_fsm
    import decrypt_pkg::*;
#(
    parameter int unsigned MSG_LEN  = DEFAULT_MSG_LEN,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        q,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              finish,
    output logic              valid,
    output logic [ADDR_W-1:0] fail_index,
    output logic [7:0]        bad_char
);

    localparam int unsigned       CntW     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CntW-1:0]   WaitLast = CntW'(READ_LAT - 1);
    // Index is one bit wider than the address so the terminal compare never wraps.
    localparam logic [ADDR_W:0]   KLast    = (ADDR_W + 1)'(MSG_LEN - 1);

    chk_state_t        state_q, state_d;
    logic [ADDR_W:0]   k_q, k_d;
    logic [CntW-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              finish_q, finish_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] fail_index_q, fail_index_d;
    logic [7:0]        bad_char_q, bad_char_d;
    logic              q_legal;

    char_is_legal u_char_is_legal (
        .char_i  (q),
        .legal_o (q_legal)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        wait_d       = wait_q;
        address_d    = address_q;
        finish_d     = 1'b0;
        valid_d      = valid_q;
        fail_index_d = fail_index_q;
        bad_char_d   = bad_char_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SET_ADDR;
                    k_d          = '0;
                    valid_d      = 1'b0;
                    fail_index_d = '0;
                    bad_char_d   = '0;
                end
            end
            SET_ADDR: begin
                address_d = k_q[ADDR_W-1:0];
                wait_d    = '0;
                state_d   = (READ_LAT == 0) ? CHECK : WAIT;
            end
            WAIT: begin
                if (wait_q == WaitLast) begin
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            CHECK: begin
                if (!q_legal) begin
                    state_d      = DONE;
                    fail_index_d = k_q[ADDR_W-1:0];
                    bad_char_d   = q;
                end else if (k_q == KLast) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = SET_ADDR;
                end
            end
            DONE: begin
                // Registered, so the pulse lands in the first IDLE cycle after DONE.
                finish_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            wait_q       <= '0;
            address_q    <= '0;
            finish_q     <= 1'b0;
            valid_q      <= 1'b0;
            fail_index_q <= '0;
            bad_char_q   <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wait_q       <= wait_d;
            address_q    <= address_d;
            finish_q     <= finish_d;
            valid_q      <= valid_d;
            fail_index_q <= fail_index_d;
            bad_char_q   <= bad_char_d;
        end
    end

    always_comb begin
        address    = address_q;
        busy       = (state_q != IDLE);
        finish     = finish_q;
        valid      = valid_q;
        fail_index = fail_index_q;
        bad_char   = bad_char_q;
    end

endmodule

// File: tb/tb_message_checker_fsm.sv
module tb_message_checker_fsm;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] q;
    logic [4:0] address;
    logic       busy;
    logic       finish;
    logic       valid;
    logic [4:0] fail_index;
    logic [7:0] bad_char;

    logic [7:0] mem [32];
    assign q = mem[address];

    message_checker_fsm #(
        .MSG_LEN  (32),
        .ADDR_W   (5),
        .READ_LAT (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .q          (q),
        .address    (address),
        .busy       (busy),
        .finish     (finish),
        .valid      (valid),
        .fail_index (fail_index),
        .bad_char   (bad_char)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // A scan accepted at edge e0 probes byte j at edge e0+1+3j; the verdict is
    // final one edge before the finish pulse, which sits in cycle [fin, fin+1].
    bit         m_scan = 1'b0;
    int         m_e0, m_fin, m_last;
    logic       m_valid;
    logic [4:0] m_fi, m_addr;
    logic [7:0] m_bc;

    function automatic int first_illegal();
        for (int i = 0; i < 32; i++) begin
            if (!(((mem[i] >= 8'h61) && (mem[i] <= 8'h7A)) || (mem[i] == 8'h20))) return i;
        end
        return -1;
    endfunction

    initial forever begin
        int bad, j;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_scan = 1'b0;
            m_addr = '0;
        end else begin
            cyc++;
            if (start && !(m_scan && cyc <= m_fin)) begin
                bad    = first_illegal();
                m_scan = 1'b1;
                m_e0   = cyc;
                if (bad < 0) begin
                    m_last  = 31;
                    m_fin   = cyc + 32 * 3 + 1;
                    m_valid = 1'b1;
                    m_fi    = '0;
                    m_bc    = '0;
                end else begin
                    m_last  = bad;
                    m_fin   = cyc + (bad + 1) * 3 + 1;
                    m_valid = 1'b0;
                    m_fi    = 5'(bad);
                    m_bc    = mem[bad];
                end
            end
            if (m_scan && cyc > m_e0 && ((cyc - m_e0 - 1) % 3) == 0) begin
                j = (cyc - m_e0 - 1) / 3;
                if (j <= m_last) m_addr = 5'(j);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;

    initial forever begin
        logic       eb, ef, ev;
        logic [4:0] efi;
        logic [7:0] ebc;
        @(negedge clock);
        if (cmp_en) begin
            eb = 1'b0; ef = 1'b0; ev = 1'b0; efi = '0; ebc = '0;
            if (m_scan) begin
                eb = (cyc >= m_e0) && (cyc < m_fin);
                ef = (cyc == m_fin);
                if (cyc >= m_fin - 1) begin
                    ev  = m_valid;
                    efi = m_fi;
                    ebc = m_bc;
                end
            end
            chk("cyc_busy",       32'(busy),       32'(eb));
            chk("cyc_finish",     32'(finish),     32'(ef));
            chk("cyc_valid",      32'(valid),      32'(ev));
            chk("cyc_fail_index", 32'(fail_index), 32'(efi));
            chk("cyc_bad_char",   32'(bad_char),   32'(ebc));
            chk("cyc_address",    32'(address),    32'(m_addr));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    task automatic run_scan(input string name, input int exp_lat, input logic exp_v,
                            input logic [4:0] exp_fi, input logic [7:0] exp_bc,
                            output logic [4:0] max_addr);
        int e0;
        int lat;
        @(negedge clock);
        #1 start = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        #1 start = 1'b0;
        lat = -1;
        max_addr = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (address > max_addr) max_addr = address;
            if (finish) begin
                lat = cyc - e0;
                break;
            end
        end
        chk({name, "_latency"},    32'(lat),        32'(exp_lat));
        chk({name, "_valid"},      32'(valid),      32'(exp_v));
        chk({name, "_fail_index"}, 32'(fail_index), 32'(exp_fi));
        chk({name, "_bad_char"},   32'(bad_char),   32'(exp_bc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] sweep_val   [5] = '{8'h1F, 8'h21, 8'h60, 8'h7A, 8'h20};
    logic       sweep_legal [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        logic [4:0] ma;
        int         e0, f1, f2, nfin, lat;
        logic       v_re, b_re;

        fill(8'h61);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_finish",  32'(finish),  32'd0);
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_address", 32'(address), 32'd0);
        #1 reset_n = 1'b1;

        // All 'a': legal, finish 97 edges after start.
        run_scan("all_a", 97, 1'b1, 5'd0, 8'h00, ma);

        // Byte 5 = '{', rest spaces.
        fill(8'h20);
        mem[5] = 8'h7B;
        run_scan("byte5", 19, 1'b0, 5'd5, 8'h7B, ma);
        chk("byte5_max_address", 32'(ma), 32'd5);

        // Boundary sweep on byte 0.
        for (int s = 0; s < 5; s++) begin
            fill(8'h61);
            mem[0] = sweep_val[s];
            if (sweep_legal[s]) run_scan($sformatf("sweep%0d", s), 97, 1'b1, 5'd0, 8'h00, ma);
            else run_scan($sformatf("sweep%0d", s), 4, 1'b0, 5'd0, sweep_val[s], ma);
        end

        // Illegal last byte exercises the terminal index.
        fill(8'h61);
        mem[31] = 8'hFF;
        run_scan("last_ff", 97, 1'b0, 5'd31, 8'hFF, ma);

        // Asynchronous reset mid-scan.
        fill(8'h61);
        @(negedge clock);
        #1 start = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 100 && cyc < e0 + 40; i++) @(negedge clock);
        chk("pre_reset_address", 32'(address), 32'd13);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_busy",    32'(busy),       32'd0);
        chk("areset_finish",  32'(finish),     32'd0);
        chk("areset_valid",   32'(valid),      32'd0);
        chk("areset_address", 32'(address),    32'd0);
        chk("areset_fi",      32'(fail_index), 32'd0);
        chk("areset_bc",      32'(bad_char),   32'd0);
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        run_scan("after_reset", 97, 1'b1, 5'd0, 8'h00, ma);

        // Start pulse mid-scan is ignored.
        @(negedge clock);
        #1 start = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        #1 start = 1'b0;
        nfin = 0;
        lat = -1;
        for (int i = 0; i < 200 && cyc < e0 + 130; i++) begin
            @(negedge clock);
            if (cyc == e0 + 50) begin
                #1 start = 1'b1;
                @(negedge clock);
                #1 start = 1'b0;
            end
            if (finish) begin
                nfin++;
                lat = cyc - e0;
            end
        end
        chk("ignore_finish_count", 32'(nfin), 32'd1);
        chk("ignore_latency",      32'(lat),  32'd97);

        // Start held high: back-to-back scans.
        @(negedge clock);
        #1 start = 1'b1;
        e0 = cyc + 1;
        f1 = -1;
        f2 = -1;
        v_re = 1'bx;
        b_re = 1'bx;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (f1 >= 0 && cyc == f1 + 1) begin
                v_re = valid;
                b_re = busy;
            end
            if (finish) begin
                if (f1 < 0) f1 = cyc;
                else begin
                    f2 = cyc;
                    break;
                end
            end
        end
        #1 start = 1'b0;
        chk("hold_first_latency", 32'(f1 - e0), 32'd97);
        chk("hold_spacing",       32'(f2 - f1), 32'd98);
        chk("hold_valid_cleared", 32'(v_re),    32'd0);
        chk("hold_busy_again",    32'(b_re),    32'd1);
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/message_checker_fsm.md
# message_checker_fsm

Reader-side counterpart to the RC4 decrypt FSM. Once that FSM has written the decrypted message RAM, this block reads it back byte by byte and reports whether every byte is printable plaintext: lowercase `a`–`z` (8'h61–8'h7A) or space (8'h20). It sits between the decrypt FSM and the top-level key-search controller, which uses `valid` to accept the current key or advance to the next one. On the first illegal byte it aborts and reports where that byte is and what it was.

## Interface
- `MSG_LEN`, 32: number of message bytes checked, at addresses 0..MSG_LEN-1.
- `ADDR_W`, 5: width of the RAM address; must satisfy 2**ADDR_W >= MSG_LEN.
- `READ_LAT`, 1: number of wait cycles between driving `address` and sampling `q`.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a check; sampled only in IDLE.
- `q`  in  8  read data from decrypted-message RAM.
- `address`  out  ADDR_W  RAM read address; registered.
- `busy`  out  1  high in every state except IDLE.
- `finish`  out  1  single-cycle pulse when the verdict is final.
- `valid`  out  1  verdict: 1 = all bytes legal; held until the next accepted `start`.
- `fail_index`  out  ADDR_W  address of the first illegal byte; 0 when `valid`=1.
- `bad_char`  out  8  value of the first illegal byte; 0 when `valid`=1.
- The block never writes the RAM and has no write-enable output.

## Operation
- States:
  - IDLE → SET_ADDR on `start`=1. On this transition: index k←0, `valid`←0, `fail_index`←0, `bad_char`←0.
  - SET_ADDR: `address`←k. → WAIT.
  - WAIT: stays for READ_LAT cycles (counter). → CHECK.
  - CHECK: `q` is sampled.
    - Legal byte and k=MSG_LEN-1 → DONE with `valid`←1.
    - Legal byte and k<MSG_LEN-1 → SET_ADDR with k←k+1.
    - Illegal byte → DONE with `valid`←0, `fail_index`←k, `bad_char`←q.
  - DONE: `finish`=1 for this one cycle. → IDLE.
- Legality test, inclusive bounds: (q >= 8'h61 && q <= 8'h7A) || q == 8'h20.
  - Boundaries 8'h1F, 8'h21, 8'h60, 8'h7B, 8'hFF are illegal.
- Index k is ADDR_W+1 bits wide so the terminal comparison cannot wrap. `address` is the low ADDR_W bits of k.
- `start` is ignored in all states except IDLE.
  - If `start` is held high through DONE, a new check begins on the first IDLE cycle.
- `valid`, `fail_index` and `bad_char` are stable from DONE until the next start acceptance.
- Reset (any state, including mid-scan) forces:
  - state=IDLE, `address`=0, `busy`=0, `finish`=0, `valid`=0, `fail_index`=0, `bad_char`=0, k=0, wait counter=0.
  - No partial verdict survives reset.

## Timing
- Cost per byte: 1 (SET_ADDR) + READ_LAT (WAIT) + 1 (CHECK) cycles; 3 cycles at the default READ_LAT=1.
- Edge E0 samples `start`=1 in IDLE.
  - All legal: `finish` is high in the cycle after edge E0 + MSG_LEN*(2+READ_LAT) + 1. Default case: edge 97, so `finish` is high from edge 97 to edge 98.
  - Illegal byte at index n: `finish` is high after edge E0 + (n+1)*(2+READ_LAT) + 1.
- `busy` rises the cycle after E0 and falls the cycle after DONE.
- Back-to-back checks: minimum one IDLE cycle between `finish` and the next SET_ADDR.
- `q` must be valid READ_LAT cycles after `address` changes. This matches the single-port altsyncram with unregistered output.

## Structure
- Package `decrypt_pkg` holds:
  - state enum `chk_state_t` {IDLE, SET_ADDR, WAIT, CHECK, DONE}.
  - constants CHAR_SPACE=8'h20, CHAR_LO_A=8'h61, CHAR_LO_Z=8'h7A, DEFAULT_MSG_LEN=32.
- One combinational sub-module, `char_is_legal` (in 8, out 1). It is reused by the key-search controller.

## Test plan
- All 32 bytes 8'h61 ("a"), start pulse → `finish` pulse exactly 97 edges after start, `valid`=1, `fail_index`=0, `bad_char`=0.
- Byte 5 = 8'h7B, others 8'h20 → `finish` at edge 19, `valid`=0, `fail_index`=5, `bad_char`=8'h7B. `address` never exceeds 5.
- Boundary sweep: byte 0 set in turn to 8'h1F, 8'h21, 8'h60, 8'h7A, 8'h20 → illegal, illegal, illegal, legal, legal.
- Assert `reset_n`=0 at edge 40 of an all-legal scan → all outputs 0 immediately, asynchronously. A restart then completes normally with `valid`=1.
- Pulse `start` again at edge 50 of a scan → ignored. Exactly one `finish` pulse, timing unchanged.
- Hold `start`=1 continuously with an all-legal message → consecutive `finish` pulses 98 edges apart. `valid` is cleared on each re-acceptance.
